// File: rtl/xor_sweep_checker.sv
// XOR network sweep checker: debounced start/clear buttons, a manual drive mode and an
// automatic four-vector sweep that scores a delayed network response against XOR.
module xor_sweep_checker #(
    parameter int          LATENCY  = 4,
    parameter logic [16:0] THRESH   = 17'h08000,
    parameter int          DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sw,
    input  logic [2:0]  button,
    input  logic [16:0] y_in,
    output logic [16:0] x1_out,
    output logic [16:0] x2_out,
    output logic [9:0]  led,
    output logic        done
);

    localparam logic [15:0] DB_MAX = 16'(DEBOUNCE - 1);
    localparam logic [7:0]  LAT    = 8'(LATENCY);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic classify(input logic [16:0] y);
        return (y[16] == 1'b0) && (y[15:0] >= THRESH[15:0]);
    endfunction

    logic [1:0]  sync1_r, sync2_r, clean_r, clean_d_r;
    logic [15:0] db_cnt_r [2];
    logic        start_pulse_s, clear_pulse_s, cls_s, unused_s;

    state_t      state_r, state_n;
    logic [1:0]  vec_r, vec_n;
    logic [7:0]  wcnt_r, wcnt_n;
    logic [3:0]  pass_bits_r, pass_bits_n;
    logic [2:0]  pass_cnt_r, pass_cnt_n, fail_cnt_r, fail_cnt_n;
    logic        x1_r, x1_n, x2_r, x2_n;
    logic        done_r, busy_r, cls_r;

    // button[2] and sw[8:2] have no function in this block
    assign unused_s = ^{button[2], sw[8:2], fail_cnt_r};

    assign start_pulse_s = clean_d_r[0] & ~clean_r[0];
    assign clear_pulse_s = clean_d_r[1] & ~clean_r[1];
    assign cls_s         = classify(y_in);

    // Button synchronizers and debouncers; clean levels rest at released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 2'b11;
            sync2_r     <= 2'b11;
            clean_r     <= 2'b11;
            clean_d_r   <= 2'b11;
            db_cnt_r[0] <= 16'd0;
            db_cnt_r[1] <= 16'd0;
        end else begin
            sync1_r   <= button[1:0];
            sync2_r   <= sync1_r;
            clean_d_r <= clean_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == clean_r[i]) begin
                    db_cnt_r[i] <= 16'd0;
                end else if (db_cnt_r[i] == DB_MAX) begin
                    clean_r[i]  <= sync2_r[i];
                    db_cnt_r[i] <= 16'd0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // Sweep FSM next-state and datapath; clear outranks every other event
    always_comb begin
        state_n     = state_r;
        vec_n       = vec_r;
        wcnt_n      = wcnt_r;
        pass_bits_n = pass_bits_r;
        pass_cnt_n  = pass_cnt_r;
        fail_cnt_n  = fail_cnt_r;
        x1_n        = x1_r;
        x2_n        = x2_r;
        if (clear_pulse_s) begin
            state_n     = IDLE;
            vec_n       = 2'd0;
            wcnt_n      = 8'd0;
            pass_bits_n = 4'd0;
            pass_cnt_n  = 3'd0;
            fail_cnt_n  = 3'd0;
            x1_n        = 1'b0;
            x2_n        = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    x1_n = sw[9] & sw[0];
                    x2_n = sw[9] & sw[1];
                    if (start_pulse_s && !sw[9]) begin
                        state_n = DRIVE;
                        vec_n   = 2'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DRIVE: begin
                    x1_n    = vec_r[0];
                    x2_n    = vec_r[1];
                    wcnt_n  = LAT;
                    state_n = (LAT <= 8'd1) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    // leaving as the count reaches 1 gives LATENCY cycles DRIVE-to-SAMPLE
                    if (wcnt_r <= 8'd2) begin
                        wcnt_n  = 8'd1;
                        state_n = SAMPLE;
                    end else begin
                        wcnt_n  = wcnt_r - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (cls_s == (vec_r[0] ^ vec_r[1])) begin
                        pass_bits_n[vec_r] = 1'b1;
                        pass_cnt_n = (pass_cnt_r < 3'd4) ? pass_cnt_r + 3'd1 : pass_cnt_r;
                    end else begin
                        fail_cnt_n = (fail_cnt_r < 3'd4) ? fail_cnt_r + 3'd1 : fail_cnt_r;
                    end
                    if (vec_r == 2'd3) begin
                        state_n = DONE;
                    end else begin
                        vec_n   = vec_r + 2'd1;
                        state_n = DRIVE;
                    end
                end
                DONE: begin
                    if (start_pulse_s) begin
                        state_n     = DRIVE;
                        vec_n       = 2'd0;
                        pass_bits_n = 4'd0;
                        pass_cnt_n  = 3'd0;
                        fail_cnt_n  = 3'd0;
                    end else begin
                        state_n = DONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state, results and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vec_r       <= 2'd0;
            wcnt_r      <= 8'd0;
            pass_bits_r <= 4'd0;
            pass_cnt_r  <= 3'd0;
            fail_cnt_r  <= 3'd0;
            x1_r        <= 1'b0;
            x2_r        <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cls_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            vec_r       <= vec_n;
            wcnt_r      <= wcnt_n;
            pass_bits_r <= pass_bits_n;
            pass_cnt_r  <= pass_cnt_n;
            fail_cnt_r  <= fail_cnt_n;
            x1_r        <= x1_n;
            x2_r        <= x2_n;
            done_r      <= (state_n == DONE);
            busy_r      <= (state_n == DRIVE) || (state_n == WAIT) || (state_n == SAMPLE);
            cls_r       <= cls_s;
        end
    end

    assign x1_out = {1'b0, {16{x1_r}}};
    assign x2_out = {1'b0, {16{x2_r}}};
    assign led    = {cls_r, busy_r, done_r, pass_cnt_r, pass_bits_r};
    assign done   = done_r;

endmodule

// File: doc/xor_sweep_checker.md
XOR_SWEEP_CHECKER -- requirements
Module: xor_sweep_checker

Interface
REQ-001 Parameter LATENCY, default 4: cycles from driving x1_out/x2_out to sampling y_in; legal range 1..255.
REQ-002 Parameter THRESH, default 17'h08000: minimum magnitude at which y_in is classified as logic 1.
REQ-003 Parameter DEBOUNCE, default 16: number of stable cycles before a button level is accepted; legal range 2..65535.
REQ-004 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sw  input  10  sw[0]/sw[1] are manual x1/x2; sw[9] = 1 selects manual mode, 0 selects sweep mode.
REQ-007 button  input  3  active-low pushbuttons; button[0] = start sweep, button[1] = clear results, button[2] unused.
REQ-008 y_in  input  17  network output, sign-magnitude (bit 16 = sign, bits 15:0 = magnitude).
REQ-009 x1_out, x2_out  output  17 each  network inputs, registered; logic 1 = 17'h0FFFF, logic 0 = 17'h00000.
REQ-010 led  output  10  status display (REQ-024).
REQ-011 done  output  1  high while the FSM is in DONE.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer that updates its clean level only after DEBOUNCE consecutive identical samples.
REQ-013 start_pulse and clear_pulse SHALL each be a one-cycle pulse on the pressed transition of the clean level (high->low raw).
REQ-014 Classification: cls = 1 iff y_in[16] == 0 and y_in[15:0] >= THRESH[15:0]; negative zero (17'h10000) classifies as 0.
REQ-015 FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
REQ-016 IDLE: if sw[9] = 1, x1_out/x2_out SHALL follow sw[0]/sw[1] with one cycle of register delay; if sw[9] = 0 they SHALL hold 0; start_pulse with sw[9] = 0 -> DRIVE with vec = 0.
REQ-017 DRIVE (1 cycle): x1_out = vec[0] encoded, x2_out = vec[1] encoded; load wait counter with LATENCY; -> WAIT.
REQ-018 WAIT: decrement counter each cycle; when it reaches 1 -> SAMPLE; total cycles from DRIVE entry to SAMPLE entry = LATENCY.
REQ-019 SAMPLE (1 cycle): compare cls with expected = vec[0] XOR vec[1]; on match set pass_bits[vec] and increment pass_cnt, otherwise increment fail_cnt; if vec == 3 -> DONE, else vec += 1 and -> DRIVE.
REQ-020 DONE: hold x1_out/x2_out at the last vector, done = 1; start_pulse -> DRIVE with vec = 0 and counters cleared (a re-run); clear_pulse -> IDLE.
REQ-021 pass_cnt and fail_cnt SHALL be 3-bit saturating (0..4); pass_cnt + fail_cnt == 4 in DONE.
REQ-022 start_pulse during DRIVE/WAIT/SAMPLE SHALL be ignored; a switch change of sw[9] mid-sweep SHALL be ignored until the FSM returns to IDLE.
REQ-023 clear_pulse in any state SHALL force IDLE and zero pass_bits, pass_cnt, fail_cnt, vec; when start_pulse and clear_pulse occur in the same cycle, clear SHALL win.
REQ-024 led[3:0] = pass_bits, led[6:4] = pass_cnt, led[7] = done, led[8] = busy (DRIVE/WAIT/SAMPLE), led[9] = cls (live, registered).

Reset
REQ-025 rst_n = 0 SHALL immediately force IDLE, x1_out = x2_out = 0, led = 0, done = 0, all counters, vec and pass_bits = 0, and debouncer clean levels = released (1).
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep with no partial results retained; after release, the FSM remains in IDLE until a new start_pulse.

Verification
REQ-027 Reset, sw[9] = 0, hold button[0] low for 20 cycles; y_in model = ideal XOR with 4-cycle delay -> exactly one sweep; done = 1; led[3:0] = 4'b1111; pass_cnt = 4.
REQ-028 Sweep with y_in stuck at 17'h0FFFF -> pass_bits = 4'b0110, pass_cnt = 2, fail_cnt = 2.
REQ-029 Bounce button[0] (toggle every 3 cycles for 30 cycles, DEBOUNCE = 16) -> no start_pulse; then hold for 20 cycles -> exactly one pulse.
REQ-030 y_in = 17'h08000 -> cls = 1; y_in = 17'h07FFF -> cls = 0; y_in = 17'h18000 -> cls = 0.
REQ-031 sw[9] = 1, sw[1:0] = 2'b10 -> x1_out = 0, x2_out = 17'h0FFFF one cycle later; start_pulse ignored.
REQ-032 Assert rst_n during WAIT of vec = 2 -> all outputs 0 within the same cycle; start_pulse and clear_pulse in the same cycle while in DONE -> IDLE with counters = 0.
